// File: rtl/rs232_tx_serialiser.sv
// 8N1 UART transmitter fed by a 32-bit stb/ack stream.
// A small FIFO lets the producer burst several characters.
module rs232_tx_serialiser #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int DEPTH           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_in,
    input  logic        input_in_stb,
    output logic        input_in_ack,
    output logic        tx
);

    localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int AW  = $clog2(DEPTH);
    localparam int BW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [BW-1:0] baud;
    logic [BW-1:0] baud_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_next;
    logic          tx_next;
    logic          bit_end;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          push;
    logic          pop;
    logic          ack_next;
    logic          unused_hi;

    assign unused_hi = ^input_in[31:8];

    assign push    = input_in_stb & input_in_ack;
    assign pop     = (state == IDLE) && (count != '0);
    assign bit_end = (baud == BAUD_LAST);

    assign count_next = count
                      + {{AW{1'b0}}, push}
                      - {{AW{1'b0}}, pop};

    // No back-to-back accepts; otherwise offer space left after this edge.
    assign ack_next = !push && (count_next != FULL);

    always_comb begin
        state_next = state;
        baud_next  = baud;
        shift_next = shift;
        bit_next   = bit_cnt;
        tx_next    = 1'b1;
        unique case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (pop) begin
                    shift_next = mem[rd_ptr];
                    bit_next   = '0;
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    bit_next   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            baud         <= '0;
            shift        <= '0;
            bit_cnt      <= '0;
            tx           <= 1'b1;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            input_in_ack <= 1'b0;
        end else begin
            state        <= state_next;
            baud         <= baud_next;
            shift        <= shift_next;
            bit_cnt      <= bit_next;
            tx           <= tx_next;
            count        <= count_next;
            input_in_ack <= ack_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= input_in[7:0];
        end
    end

endmodule

// File: tb/tb_rs232_tx_serialiser.sv
// Bench for rs232_tx_serialiser: line decoder plus byte scoreboard,
// table-driven single frames and directed burst/reset/stall sequences.
module tb_rs232_tx_serialiser;

    localparam int CPB = 10;

    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] input_in = '0;
    logic        input_in_stb = 1'b0;
    logic        input_in_ack;
    logic        tx;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int n_push = 0;
    int frames = 0;
    int last_acc = 0;
    int last_start = 0;
    logic busy = 1'b0;
    logic [7:0] last_byte = '0;

    logic [7:0] sb[$];
    int acc_q[$];
    int start_q[$];

    rs232_tx_serialiser #(
        .CLOCK_FREQUENCY(1000000),
        .BAUD_RATE      (100000),
        .DEPTH          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .input_in    (input_in),
        .input_in_stb(input_in_stb),
        .input_in_ack(input_in_ack),
        .tx          (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] w, input logic hold);
        int n0;
        int t;
        n0 = n_push;
        t = 0;
        input_in = w;
        input_in_stb = 1'b1;
        while (n_push == n0 && t < 2000) begin
            tick();
            t++;
        end
        if (n_push == n0) fail("send_timeout");
        if (!hold) input_in_stb = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy) && t < 3000) begin
            tick();
            t++;
        end
        if (sb.size() != 0 || busy) fail("idle_timeout");
        repeat (3) tick();
    endtask

    // Transfer observer: stb&ack seen here means a transfer on the next edge.
    initial begin : xfer_monitor
        forever begin
            @(negedge clk);
            if (rst && input_in_stb && input_in_ack) begin
                sb.push_back(input_in[7:0]);
                acc_q.push_back(cyc + 1);
                last_acc = cyc + 1;
                n_push++;
            end
        end
    end

    initial begin : line_monitor
        logic [9:0] bits;
        logic shape_ok;
        logic abort;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                busy = 1'b1;
                last_start = cyc;
                start_q.push_back(cyc);
                shape_ok = 1'b1;
                abort = 1'b0;
                bits = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < CPB; j++) begin
                        if (k != 0 || j != 0) @(negedge clk);
                        if (!rst) abort = 1'b1;
                        if (j == 0) bits[k] = tx;
                        else if (tx !== bits[k]) shape_ok = 1'b0;
                    end
                end
                busy = 1'b0;
                if (!abort) begin
                    check("frame_start_stop", {30'd0, bits[9], bits[0]}, 2);
                    check("frame_bit_width", {31'd0, shape_ok}, 1);
                    last_byte = bits[8:1];
                    if (sb.size() == 0) begin
                        fail("unexpected_frame");
                    end else begin
                        exp_b = sb.pop_front();
                        check("frame_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
                    end
                    frames++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[8];
        int a;
        int f0;
        int n0;
        int t;
        int lows;
        logic [7:0] b;

        vecs[0] = '{word: 32'h0000_00A5, exp: 8'hA5};
        vecs[1] = '{word: 32'hFFFF_FF00, exp: 8'h00};
        vecs[2] = '{word: 32'h0000_0000, exp: 8'h00};
        vecs[3] = '{word: 32'h0000_005A, exp: 8'h5A};
        vecs[4] = '{word: 32'hABCD_EF80, exp: 8'h80};
        vecs[5] = '{word: 32'h0000_0001, exp: 8'h01};
        vecs[6] = '{word: 32'h1234_56FF, exp: 8'hFF};
        vecs[7] = '{word: 32'h8000_00C3, exp: 8'hC3};

        // Reset held with a pending producer.
        rst = 1'b0;
        input_in = 32'h55;
        input_in_stb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_tx", {31'd0, tx}, 1);
            check("reset_ack", {31'd0, input_in_ack}, 0);
        end
        rst = 1'b1;
        input_in_stb = 1'b0;
        tick();
        check("ack_after_release", {31'd0, input_in_ack}, 1);

        // Single frames from the table.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].word, 1'b0);
            a = last_acc;
            wait_idle();
            check("first_start_latency", last_start - a, 2);
            check("table_byte", {24'd0, last_byte}, {24'd0, vecs[i].exp});
        end

        // Burst with backpressure and pointer wrap.
        acc_q.delete();
        start_q.delete();
        f0 = frames;
        for (int i = 1; i <= 8; i++) send(i, 1'b1);
        input_in_stb = 1'b0;
        wait_idle();
        check("burst_frames", frames - f0, 8);
        check("burst_accepts", acc_q.size(), 8);
        for (int i = 1; i < 5; i++) check("burst_fill_spacing", acc_q[i] - acc_q[i-1], 2);
        check("burst_first_refill", acc_q[5] - acc_q[0], 103);
        for (int i = 6; i < 8; i++) check("burst_refill_spacing", acc_q[i] - acc_q[i-1], 101);
        check("burst_first_latency", start_q[0] - acc_q[0], 2);
        for (int i = 1; i < 8; i++) check("burst_frame_period", start_q[i] - start_q[i-1], 101);

        // Reset during data bit 3 with two words queued.
        send(32'h3C, 1'b0);
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        t = 0;
        while (!(busy && cyc >= last_start + 43) && t < 500) begin
            tick();
            t++;
        end
        if (!busy) fail("mid_frame_not_reached");
        rst = 1'b0;
        sb.delete();
        tick();
        check("mid_reset_tx", {31'd0, tx}, 1);
        check("mid_reset_ack", {31'd0, input_in_ack}, 0);
        tick();
        rst = 1'b1;
        lows = 0;
        f0 = frames;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("idle_after_reset_lows", lows, 0);
        check("idle_after_reset_frames", frames - f0, 0);
        wait_idle();

        // Producer that stalls randomly between words.
        f0 = frames;
        n0 = n_push;
        for (int i = 0; i < 50; i++) begin
            b = 8'($urandom_range(255));
            input_in_stb = 1'b0;
            input_in = {24'($urandom), b};
            while ($urandom_range(99) >= 30) tick();
            send({24'($urandom), b}, 1'b0);
        end
        wait_idle();
        check("stall_frames", frames - f0, 50);
        check("stall_accepts", n_push - n0, 50);
        check("stall_scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
